stop_ptos: RTL and testbench
============================

STOP_PTOS -- requirements
Module: stop_ptos

Interface
REQ-001 Parameter RX_WIDTH, default 10, bit count of each word assembled by the receive shifter.
REQ-002 Parameter TX_WIDTH, default 8, bit count of each word serialised by the transmit shifter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 serial_in  input  1  receive serial data (MOSI), sampled on rising clk.
REQ-006 rx_enable  input  1  receive shifter enable.
REQ-007 rx_data  output  RX_WIDTH  last fully assembled receive word (registered).
REQ-008 rx_done  output  1  one-cycle pulse marking a newly completed rx_data word.
REQ-009 tx_valid  input  1  request to load tx_data into the transmit shifter.
REQ-010 tx_data  input  TX_WIDTH  parallel word to transmit.
REQ-011 serial_out  output  1  transmit serial data (MISO), registered.
REQ-012 tx_busy  output  1  high while a transmit word is being shifted out.

Function -- receive (serial to parallel)
REQ-013 While rx_enable=1, each rising clk SHALL shift serial_in into an internal register, MSB first (first sampled bit ends in rx_data[RX_WIDTH-1]).
REQ-014 A bit counter SHALL count sampled bits 0..RX_WIDTH-1; on the edge sampling bit RX_WIDTH-1, rx_data SHALL load the complete word and rx_done SHALL be 1 for exactly that following cycle.
REQ-015 After completion the counter SHALL wrap to 0; with rx_enable still 1 the next edge begins a new word with no gap.
REQ-016 rx_data SHALL hold its value between completions; partial words SHALL never appear on rx_data.
REQ-017 rx_enable=0 on an edge SHALL clear the counter and partial register, hold rx_data, drive rx_done=0; a later word restarts from bit 0.
REQ-018 rx_done SHALL be 0 in every cycle other than the one after a completing edge.

Function -- transmit (parallel to serial)
REQ-019 States: IDLE (tx_busy=0) and SHIFT (tx_busy=1).
REQ-020 IDLE, tx_valid=1 at edge L: load tx_data, serial_out=tx_data[TX_WIDTH-1], enter SHIFT; tx_valid=0: serial_out=0, stay IDLE.
REQ-021 SHIFT: edges L+1..L+TX_WIDTH-1 SHALL drive tx_data bits TX_WIDTH-2 down to 0, MSB first, one bit per clock.
REQ-022 tx_valid and tx_data SHALL be ignored in SHIFT before edge L+TX_WIDTH; the latched word SHALL not change if tx_data changes.
REQ-023 Edge L+TX_WIDTH (last bit already driven one cycle): tx_valid=1 SHALL load the new word exactly as REQ-020 (back-to-back, no idle bit); tx_valid=0 SHALL return to IDLE with serial_out=0.
REQ-024 tx_busy SHALL be 1 in cycles after edges L..L+TX_WIDTH-1 and 0 otherwise, unless reloaded per REQ-023.
REQ-025 Receive and transmit paths SHALL be fully independent and operate concurrently.

Reset
REQ-026 rst=0 SHALL immediately, without clk, force: rx_data=0, rx_done=0, receive counter/register=0, serial_out=0, tx_busy=0, transmit state IDLE.
REQ-027 Reset asserted mid-word SHALL abandon the word on either path; after release the receive path restarts at bit 0 and transmit waits for a new tx_valid.
REQ-028 Reset release SHALL be sampled on rising clk; the first edge with rst=1 performs normal operation.

Verification
REQ-029 rx_enable=1, serial_in 1,0,1,1,0,0,1,1,1,0 over 10 edges -> rx_data=10'b1011001110 and rx_done=1 for one cycle after 10th edge, 0 elsewhere.
REQ-030 Two consecutive words 10'h3FF then 10'h001 with rx_enable held -> rx_done pulses after edges 10 and 20; rx_data 0x3FF then 0x001, unchanged in between.
REQ-031 rx_enable dropped after 4 bits, then raised and 10 bits of 10'h155 sent -> single rx_done, rx_data=0x155.
REQ-032 tx_valid=1 for one cycle with tx_data=8'hA5 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, tx_busy=1 for those 8, then serial_out=0, tx_busy=0.
REQ-033 tx_valid held with 8'hC3 then 8'h3C at edge L+8 -> 16 contiguous bits 11000011 00111100, tx_busy high throughout; tx_data change mid-word ignored.
REQ-034 rst=0 asserted between clock edges mid-transmit and mid-receive -> all outputs 0 immediately; after release 8'h81 transmits correctly and a fresh 10-bit word assembles correctly.

Source files
------------

// File: rtl/stop_ptos.sv
// Serial/parallel shifter pair: independent MSB-first receive assembler and transmit serialiser.
// Receive builds RX_WIDTH-bit words from serial_in; transmit streams TX_WIDTH-bit words on serial_out.
module stop_ptos #(
    parameter int unsigned RX_WIDTH = 10,
    parameter int unsigned TX_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                rx_enable,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_done,
    input  logic                tx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    output logic                serial_out,
    output logic                tx_busy
);

    localparam int unsigned RX_CW = (RX_WIDTH > 1) ? $clog2(RX_WIDTH) : 1;
    localparam int unsigned TX_CW = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // ---------------------------------------------------------------- receive
    logic [RX_WIDTH-2:0] r_rx_shift;
    logic [RX_CW-1:0]    r_rx_cnt;
    logic [RX_WIDTH-1:0] r_rx_data;
    logic                r_rx_done;
    logic [RX_WIDTH-1:0] w_rx_word;
    logic                w_rx_last;

    assign w_rx_word = {r_rx_shift, serial_in};
    assign w_rx_last = (r_rx_cnt == RX_CW'(RX_WIDTH - 1));

    // Partial bits live only in r_rx_shift; rx_data is updated solely on word completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
        end else if (!rx_enable) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_done  <= 1'b0;
        end else if (w_rx_last) begin
            r_rx_data  <= w_rx_word;
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_done  <= 1'b1;
        end else begin
            r_rx_shift <= w_rx_word[RX_WIDTH-2:0];
            r_rx_cnt   <= r_rx_cnt + RX_CW'(1);
            r_rx_done  <= 1'b0;
        end
    end

    assign rx_data = r_rx_data;
    assign rx_done = r_rx_done;

    // --------------------------------------------------------------- transmit
    tx_state_t           r_tx_state;
    tx_state_t           w_tx_state_nxt;
    logic [TX_WIDTH-2:0] r_tx_shift;
    logic [TX_CW-1:0]    r_tx_cnt;
    logic                r_serial_out;
    logic                r_tx_busy;
    logic [TX_WIDTH-2:0] w_tx_shift_nxt;
    logic [TX_CW-1:0]    w_tx_cnt_nxt;
    logic                w_serial_out_nxt;
    logic                w_tx_busy_nxt;
    logic [TX_WIDTH-1:0] w_tx_shl;
    logic                w_tx_last;
    logic                w_tx_load;

    // r_tx_cnt holds the number of bits still to drive after the current one
    assign w_tx_shl  = {r_tx_shift, 1'b0};
    assign w_tx_last = (r_tx_cnt == '0);
    assign w_tx_load = tx_valid && ((r_tx_state == TX_IDLE) || w_tx_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state   <= TX_IDLE;
            r_tx_shift   <= '0;
            r_tx_cnt     <= '0;
            r_serial_out <= 1'b0;
            r_tx_busy    <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state_nxt;
            r_tx_shift   <= w_tx_shift_nxt;
            r_tx_cnt     <= w_tx_cnt_nxt;
            r_serial_out <= w_serial_out_nxt;
            r_tx_busy    <= w_tx_busy_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (tx_valid) w_tx_state_nxt = TX_SHIFT;
            TX_SHIFT: if (w_tx_last && !tx_valid) w_tx_state_nxt = TX_IDLE;
            default:  w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // A new word is accepted only when idle or right after the final bit has been on the line
    always_comb begin
        w_tx_shift_nxt   = r_tx_shift;
        w_tx_cnt_nxt     = r_tx_cnt;
        w_serial_out_nxt = 1'b0;
        w_tx_busy_nxt    = (w_tx_state_nxt == TX_SHIFT);
        if (w_tx_load) begin
            w_serial_out_nxt = tx_data[TX_WIDTH-1];
            w_tx_shift_nxt   = tx_data[TX_WIDTH-2:0];
            w_tx_cnt_nxt     = TX_CW'(TX_WIDTH - 1);
        end else if ((r_tx_state == TX_SHIFT) && !w_tx_last) begin
            w_serial_out_nxt = w_tx_shl[TX_WIDTH-1];
            w_tx_shift_nxt   = w_tx_shl[TX_WIDTH-2:0];
            w_tx_cnt_nxt     = r_tx_cnt - TX_CW'(1);
        end
    end

    assign serial_out = r_serial_out;
    assign tx_busy    = r_tx_busy;

endmodule

// File: tb/tb_stop_ptos.sv
// Directed scoreboard bench for stop_ptos: expected rx words and tx bits are queued
// as stimulus is driven and compared after each clock edge.
module tb_stop_ptos;

    localparam int unsigned RXW = 10;
    localparam int unsigned TXW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           serial_in;
    logic           rx_enable;
    logic [RXW-1:0] rx_data;
    logic           rx_done;
    logic           tx_valid;
    logic [TXW-1:0] tx_data;
    logic           serial_out;
    logic           tx_busy;

    logic [RXW-1:0] rx_q[$];
    logic           tx_q[$];
    logic [RXW-1:0] last_rx;
    int             errors = 0;
    int             checks = 0;

    stop_ptos #(.RX_WIDTH(RXW), .TX_WIDTH(TXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .rx_enable  (rx_enable),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .serial_out (serial_out),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [TXW-1:0] d);
        for (int i = TXW - 1; i >= 0; i--) tx_q.push_back(d[i]);
    endtask

    // Drive one cycle of inputs, clock once, then score both paths
    task automatic step(input logic sin, input logic ren, input logic tv, input logic [TXW-1:0] td);
        logic [RXW-1:0] exp_w;
        logic           exp_b;
        serial_in = sin;
        rx_enable = ren;
        tx_valid  = tv;
        tx_data   = td;
        @(posedge clk);
        #1;
        if (rx_q.size() > 0) begin
            exp_w = rx_q.pop_front();
            check("rx_done pulse", 32'(rx_done), 32'd1);
            check("rx_data word", 32'(rx_data), 32'(exp_w));
            last_rx = exp_w;
        end else begin
            check("rx_done quiet", 32'(rx_done), 32'd0);
            check("rx_data hold", 32'(rx_data), 32'(last_rx));
        end
        if (tx_q.size() > 0) begin
            exp_b = tx_q.pop_front();
            check("serial_out bit", 32'(serial_out), 32'(exp_b));
            check("tx_busy active", 32'(tx_busy), 32'd1);
        end else begin
            check("serial_out idle", 32'(serial_out), 32'd0);
            check("tx_busy idle", 32'(tx_busy), 32'd0);
        end
    endtask

    task automatic rx_word(input logic [RXW-1:0] w);
        for (int i = 0; i < int'(RXW); i++) begin
            if (i == int'(RXW) - 1) rx_q.push_back(w);
            step(w[RXW-1-i], 1'b1, 1'b0, 8'h00);
        end
    endtask

    initial begin
        logic [RXW-1:0] w;
        rst       = 1'b0;
        serial_in = 1'b0;
        rx_enable = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        last_rx   = '0;
        #2;
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset rx_done", 32'(rx_done), 32'd0);
        check("reset serial_out", 32'(serial_out), 32'd0);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Single receive word
        rx_word(10'b1011001110);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Back-to-back receive words, no gap
        rx_word(10'h3FF);
        rx_word(10'h001);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Partial word abandoned by dropping rx_enable
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        rx_word(10'h155);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Single transmit word
        push_tx(8'hA5);
        step(1'b0, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Back-to-back transmit; tx_valid/tx_data changes mid-word are ignored
        push_tx(8'hC3);
        step(1'b0, 1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 8'hFF);
        push_tx(8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-transmit and mid-receive
        push_tx(8'hA5);
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        check("async rst rx_data", 32'(rx_data), 32'd0);
        check("async rst rx_done", 32'(rx_done), 32'd0);
        check("async rst serial_out", 32'(serial_out), 32'd0);
        check("async rst tx_busy", 32'(tx_busy), 32'd0);
        rx_q.delete();
        tx_q.delete();
        last_rx = '0;
        @(posedge clk);
        #1;
        check("held rst rx_data", 32'(rx_data), 32'd0);
        check("held rst tx_busy", 32'(tx_busy), 32'd0);
        #3;
        rst = 1'b1;

        // Concurrent fresh words after reset release
        w = 10'h2A7;
        for (int i = 0; i < int'(RXW); i++) begin
            if (i == 0) push_tx(8'h81);
            if (i == int'(RXW) - 1) rx_q.push_back(w);
            step(w[RXW-1-i], 1'b1, (i == 0), 8'h81);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        check("rx scoreboard drained", 32'(rx_q.size()), 32'd0);
        check("tx scoreboard drained", 32'(tx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
